// File: rtl/sdram_wrbuf.sv
// rtl/sdram_wrbuf.sv - posted-write FIFO ahead of an SDRAM toggle-handshake request port
// Optional read-after-write forwarding is built when SDRAM_WRBUF_RAW_FWD_EN is defined.
module sdram_wrbuf #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:1] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic        cpu_wrl,
    input  logic        cpu_wrh,
    input  logic        cpu_req,
    output logic        cpu_busy,
    output logic [15:0] cpu_dout,
    output logic        cpu_rdy,
    output logic [24:1] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_wrl,
    output logic        ram_wrh,
    output logic        ram_req,
    input  logic        ram_ack,
    input  logic [15:0] ram_dout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR_WAIT = 2'd1, RD_WAIT = 2'd2} state_t;
    state_t state_q, state_d;

    // Entry layout: {addr[41:18], din[17:2], wrh[1], wrl[0]}
    logic [41:0]   fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          rd_pend_q, rd_pend_d;
    logic [24:1]   rd_addr_q, rd_addr_d;
    logic [24:1]   ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q, ram_din_d;
    logic          ram_wrl_q, ram_wrl_d, ram_wrh_q, ram_wrh_d;
    logic          ram_req_q, ram_req_d;
    logic [15:0]   cpu_dout_q, cpu_dout_d;
    logic          cpu_rdy_q, cpu_rdy_d;

    logic        full, empty, done, wr_acc, rd_acc;
    logic [41:0] head;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}};
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign done     = ram_ack == ram_req_q;
    assign cpu_busy = full | rd_pend_q | (state_q == RD_WAIT);
    assign wr_acc   = cpu_req & ~cpu_busy & (cpu_wrl | cpu_wrh);
    assign rd_acc   = cpu_req & ~cpu_busy & ~cpu_wrl & ~cpu_wrh;
    assign head     = fifo_q[rd_ptr_q[DEPTH_LOG2-1:0]];

`ifdef SDRAM_WRBUF_RAW_FWD_EN
    logic [PW-1:0]         occ;
    logic [DEPTH_LOG2-1:0] idx;

    // Scan oldest to newest so the last match wins, i.e. the newest write to that address.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        occ      = wr_ptr_q - rd_ptr_q;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q[DEPTH_LOG2-1:0] + DEPTH_LOG2'(i);
            if (PW'(i) < occ && fifo_q[idx][41:18] == cpu_addr) begin
                fwd_hit  = fifo_q[idx][1] & fifo_q[idx][0];
                fwd_data = fifo_q[idx][17:2];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty)        state_d = WR_WAIT;
                else if (rd_pend_q) state_d = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d   = rd_ptr_q;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_wrl_d  = ram_wrl_q;
        ram_wrh_d  = ram_wrh_q;
        ram_req_d  = ram_req_q;
        cpu_dout_d = cpu_dout_q;
        cpu_rdy_d  = 1'b0;
        if (rd_acc) begin
            if (fwd_hit) begin
                cpu_dout_d = fwd_data;
                cpu_rdy_d  = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = cpu_addr;
            end
        end
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    ram_addr_d = head[41:18];
                    ram_din_d  = head[17:2];
                    ram_wrh_d  = head[1];
                    ram_wrl_d  = head[0];
                    ram_req_d  = ~ram_req_q;
                end else if (rd_pend_q) begin
                    ram_addr_d = rd_addr_q;
                    ram_wrh_d  = 1'b0;
                    ram_wrl_d  = 1'b0;
                    ram_req_d  = ~ram_req_q;
                end
            end
            WR_WAIT: if (done) rd_ptr_d = rd_ptr_q + PW'(1);
            RD_WAIT: begin
                if (done) begin
                    cpu_dout_d = ram_dout;
                    cpu_rdy_d  = 1'b1;
                    rd_pend_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wrl_q  <= 1'b0;
            ram_wrh_q  <= 1'b0;
            ram_req_q  <= 1'b0;
            cpu_dout_q <= '0;
            cpu_rdy_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_addr_q  <= rd_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_wrl_q  <= ram_wrl_d;
            ram_wrh_q  <= ram_wrh_d;
            ram_req_q  <= ram_req_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_rdy_q  <= cpu_rdy_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc) fifo_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {cpu_addr, cpu_din, cpu_wrh, cpu_wrl};
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_wrl  = ram_wrl_q;
    assign ram_wrh  = ram_wrh_q;
    assign ram_req  = ram_req_q;
    assign cpu_dout = cpu_dout_q;
    assign cpu_rdy  = cpu_rdy_q;
endmodule

// File: tb/tb_sdram_wrbuf.sv
// tb/tb_sdram_wrbuf.sv - randomized self-checking bench for sdram_wrbuf against a request-level model
module tb_sdram_wrbuf;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:1] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic        cpu_wrl = 1'b0, cpu_wrh = 1'b0, cpu_req = 1'b0;
    logic        cpu_busy, cpu_rdy;
    logic [15:0] cpu_dout;
    logic [24:1] ram_addr;
    logic [15:0] ram_din;
    logic        ram_wrl, ram_wrh, ram_req;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_dout = '0;

    always #5 clk = ~clk;

    sdram_wrbuf #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wrl(cpu_wrl), .cpu_wrh(cpu_wrh),
        .cpu_req(cpu_req), .cpu_busy(cpu_busy), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wrl(ram_wrl), .ram_wrh(ram_wrh),
        .ram_req(ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout)
    );

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] din;
        logic        wrh;
        logic        wrl;
    } txn_t;

    int checks = 0, failures = 0;

    // Request-level model: what the controller must see, what the CPU must read back
    txn_t        exp_txn[$];
    txn_t        fifo_m[$];
    logic [15:0] exp_rd[$];
    logic [15:0] sd_mem[int];
    logic [15:0] cpu_mem[int];
    int          pops_due = 0;
    bit          rd_out = 0;
    int          rd_age = 0;
    logic [15:0] last_dout = '0;
    int          n_wr_acc = 0;

    // Controller model
    bit   pend = 0;
    int   cnt = 0;
    txn_t cap;
    bit   stall = 0;
    int   lat_lo = 5, lat_hi = 20;
    int   toggles = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input txn_t t);
        return {t.wrh ? t.din[15:8] : old[15:8], t.wrl ? t.din[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] sd_read(input logic [23:0] a);
        return sd_mem.exists(int'(a)) ? sd_mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [15:0] cpu_read(input logic [23:0] a);
        return cpu_mem.exists(int'(a)) ? cpu_mem[int'(a)] : init_word(a);
    endfunction

    task automatic observe();
        txn_t        e;
        logic [15:0] d;
        for (int i = 0; i < pops_due; i++) void'(fifo_m.pop_front());
        pops_due = 0;
        if (cpu_rdy) begin
            if (exp_rd.size() == 0) chk("rdy_unexpected", 1, 0);
            else begin
                d = exp_rd.pop_front();
                chk("rd_data", cpu_dout, d);
            end
            rd_out    = 0;
            last_dout = cpu_dout;
        end else begin
            chk("dout_hold", cpu_dout, last_dout);
        end
        chk("busy", cpu_busy, (fifo_m.size() == DEPTH) || rd_out);
        if (rd_out) begin
            rd_age++;
            if (rd_age > 3000) begin
                chk("rd_timeout", 1, 0);
                rd_out = 0;
            end
        end
        if (ram_req !== prev_req) toggles++;
        prev_req = ram_req;
        if (ram_req !== ram_ack) begin
            if (!pend) begin
                pend = 1;
                cap  = '{ram_addr, ram_din, ram_wrh, ram_wrl};
                cnt  = $urandom_range(lat_hi, lat_lo);
                if (exp_txn.size() == 0) chk("txn_unexpected", 1, 0);
                else begin
                    e = exp_txn.pop_front();
                    chk("txn_addr", ram_addr, e.addr);
                    chk("txn_wr", {ram_wrh, ram_wrl}, {e.wrh, e.wrl});
                    if (e.wrh | e.wrl) chk("txn_din", ram_din, e.din);
                end
            end else begin
                chk("ram_stable", {ram_addr, ram_din, ram_wrh, ram_wrl}, cap);
            end
            if (!stall) begin
                cnt--;
                if (cnt <= 0) begin
                    if (cap.wrl | cap.wrh) begin
                        sd_mem[int'(cap.addr)] = merge(sd_read(cap.addr), cap);
                        ram_dout = 16'($urandom);
                        pops_due++;
                    end else begin
                        ram_dout = sd_read(cap.addr);
                    end
                    ram_ack = ~ram_ack;
                    pend    = 0;
                end
            end
        end else if (pend) begin
            chk("req_retract", 1, 0);
            pend = 0;
        end
    endtask

    task automatic drive(input bit req, input logic [23:0] a, input logic [15:0] d,
                         input bit wl, input bit wh);
        txn_t t;
        bit   fwd;
        cpu_req  = req;
        cpu_addr = a;
        cpu_din  = d;
        cpu_wrl  = wl;
        cpu_wrh  = wh;
        if (req && !((fifo_m.size() == DEPTH) || rd_out)) begin
            if (wl | wh) begin
                t = '{a, d, wh, wl};
                fifo_m.push_back(t);
                exp_txn.push_back(t);
                cpu_mem[int'(a)] = merge(cpu_read(a), t);
                n_wr_acc++;
            end else begin
                fwd = 0;
`ifdef SDRAM_WRBUF_RAW_FWD_EN
                for (int i = fifo_m.size() - 1; i >= 0; i--) begin
                    if (fifo_m[i].addr == a) begin
                        fwd = fifo_m[i].wrl & fifo_m[i].wrh;
                        break;
                    end
                end
`endif
                exp_rd.push_back(cpu_read(a));
                rd_out = 1;
                rd_age = 0;
                if (!fwd) exp_txn.push_back('{a, 16'h0, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic tick(input bit req, input logic [23:0] a, input logic [15:0] d,
                        input bit wl, input bit wh);
        @(negedge clk);
        observe();
        drive(req, a, d, wl, wh);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 24'h0, 16'h0, 0, 0);
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((exp_txn.size() != 0 || pend || rd_out || fifo_m.size() != 0) && k < max) begin
            tick(0, 24'h0, 16'h0, 0, 0);
            k++;
        end
        chk("drain_done", k < max, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        ram_ack = 1'b0;
        @(negedge clk);
        chk("rst_busy", cpu_busy, 0);
        chk("rst_dout", cpu_dout, 0);
        chk("rst_rdy", cpu_rdy, 0);
        chk("rst_ram", {ram_addr, ram_din, ram_wrl, ram_wrh, ram_req}, 0);
        reset = 1'b0;
        fifo_m.delete();
        exp_txn.delete();
        exp_rd.delete();
        rd_out    = 0;
        pops_due  = 0;
        pend      = 0;
        prev_req  = 1'b0;
        last_dout = '0;
        toggles   = 0;
        n_wr_acc  = 0;
        cpu_mem   = sd_mem;
    endtask

    initial begin
        int  rdy_seen;
        bit  got;
        int  r;

        // Burst fill: 8 writes accepted, the 9th sees busy, exactly 8 toggles
        do_reset();
        stall = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1, 24'h100 + 24'(i), 16'hA000 + 16'(i), 1, 1);
            chk("burst_busy", cpu_busy, 0);
        end
        tick(1, 24'h108, 16'hA008, 1, 1);
        chk("ninth_busy", cpu_busy, 1);
        stall = 0;
        drain(1000);
        chk("burst_toggles", toggles, 8);

        // Partial write then read of the same word: read ordered after the write
        tick(1, 24'h200, 16'h1234, 1, 0);
        tick(1, 24'h200, 16'h0, 0, 0);
        rdy_seen = 0;
        for (int i = 0; i < 200 && exp_rd.size() != 0; i++) begin
            tick(0, 24'h0, 16'h0, 0, 0);
            if (cpu_rdy) begin
                rdy_seen++;
                chk("raw_partial", cpu_dout, 16'h5834);
            end
        end
        idle(3);
        chk("raw_rdy_count", rdy_seen, 1);

        // Fixed latency with continuous pushes so pops and pushes coincide
        lat_lo = 10;
        lat_hi = 10;
        n_wr_acc = 0;
        toggles  = 0;
        for (int i = 0; i < 60; i++) tick(1, 24'h500 + 24'(i), 16'(i * 3 + 7), 1, 1);
        drain(2000);
        chk("pp_toggles", toggles, n_wr_acc);
        lat_lo = 5;
        lat_hi = 20;

        // Reset while a write is outstanding with 3 entries queued
        stall = 1;
        for (int i = 0; i < 3; i++) tick(1, 24'h600 + 24'(i), 16'h7000 + 16'(i), 1, 1);
        idle(2);
        do_reset();
        stall = 0;
        idle(30);
        chk("post_reset_toggles", toggles, 0);

        // Full write held in the FIFO, then a read of the same address
        stall = 1;
        tick(1, 24'h300, 16'hBEEF, 1, 1);
        idle(2);
        tick(1, 24'h300, 16'h0, 0, 0);
        tick(0, 24'h0, 16'h0, 0, 0);
`ifdef SDRAM_WRBUF_RAW_FWD_EN
        chk("fwd_rdy", cpu_rdy, 1);
        chk("fwd_data", cpu_dout, 16'hBEEF);
        stall = 0;
        drain(500);
        chk("fwd_toggles", toggles, 1);
`else
        chk("nofwd_rdy", cpu_rdy, 0);
        stall = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick(0, 24'h0, 16'h0, 0, 0);
            if (cpu_rdy) begin
                got = 1;
                chk("nofwd_data", cpu_dout, 16'hBEEF);
            end
        end
        chk("nofwd_got", got, 1);
        drain(500);
        chk("nofwd_toggles", toggles, 2);
`endif

        // Random mix against the byte-accurate controller model
        for (int n = 0; n < 2000; ) begin
            if ($urandom_range(1, 0) == 1) begin
                r = $urandom_range(3, 0);
                tick(1, 24'h400 + 24'($urandom_range(15, 0)), 16'($urandom),
                     r[0], r[1]);
                n++;
            end else begin
                tick(0, 24'h0, 16'h0, 0, 0);
            end
        end
        drain(3000);
        chk("end_txn_empty", exp_txn.size(), 0);
        chk("end_rd_empty", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sdram_wrbuf.md
# sdram_wrbuf

Posted-write buffer for one SDRAM controller request port. Sits directly upstream of the controller's toggle-handshake port (addrN/wrlN/wrhN/dinN/reqN/ackN/doutN). It absorbs bursts of CPU/chipset writes into a FIFO and retires them one at a time, so the requester does not stall for each write. Reads are ordered behind all queued writes.

## Interface
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 entries. Legal range is 1..5.
- clk  in  1  Controller clock (up to 128 MHz). Every flop in the block is on this clock.
- reset  in  1  Asynchronous, active-high reset.
- cpu_addr  in  24 [24:1]  Word address of the request.
- cpu_din  in  16  Write data.
- cpu_wrl, cpu_wrh  in  1 each  Byte write enables. If either is set the request is a write; if both are 0 it is a read.
- cpu_req  in  1  Single-cycle request strobe. It is accepted only when cpu_busy=0.
- cpu_busy  out  1  Request cannot be accepted this cycle.
- cpu_dout  out  16  Read data. Holds its value until the next read completes.
- cpu_rdy  out  1  One-cycle pulse when cpu_dout is valid.
- ram_addr  out  24 [24:1]  To the controller's addrN.
- ram_din  out  16  To the controller's dinN.
- ram_wrl, ram_wrh  out  1 each  To the controller's wrlN/wrhN.
- ram_req  out  1  Toggle request to the controller's reqN.
- ram_ack  in  1  Toggle acknowledge from the controller's ackN.
- ram_dout  in  16  From the controller's doutN.

## Operation
- FIFO entry: {addr[24:1], din[15:0], wrh, wrl}, 42 bits. Pointers are DEPTH_LOG2+1 bits wide; the extra bit is the wrap bit.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- cpu_busy = full | rd_pend | (state != IDLE && state is a read state).
- Write accept: cpu_req & ~cpu_busy & (cpu_wrl|cpu_wrh) pushes an entry. The write pointer increments modulo 2^(DEPTH_LOG2+1).
- Read accept: cpu_req & ~cpu_busy & ~cpu_wrl & ~cpu_wrh latches cpu_addr into rd_addr and sets rd_pend.
- A transaction is outstanding while ram_req != ram_ack.
- State machine (IDLE, WR_WAIT, RD_WAIT):
  - IDLE, FIFO not empty: drive ram_* from the head entry, toggle ram_req, go to WR_WAIT. Head data stays registered on ram_* until ack.
  - IDLE, FIFO empty, rd_pend=1: drive ram_addr=rd_addr, ram_wrl=ram_wrh=0, toggle ram_req, go to RD_WAIT.
  - WR_WAIT, ram_ack==ram_req: pop head (read pointer +1), go to IDLE.
  - RD_WAIT, ram_ack==ram_req: cpu_dout<=ram_dout, pulse cpu_rdy, clear rd_pend, go to IDLE.
- Writes queued before a read always retire before that read is issued (no reordering).
- Simultaneous push and pop in the same cycle: both take effect, and occupancy is unchanged.
- A push when full is impossible because cpu_busy blocks it. A cpu_req while busy is ignored and not remembered.
- ram_* outputs stay stable while a transaction is outstanding.

## Timing
- Reset values:
  - cpu_busy=0, cpu_dout=0, cpu_rdy=0.
  - ram_addr=0, ram_din=0, ram_wrl=0, ram_wrh=0, ram_req=0.
  - Pointers=0, rd_pend=0, state=IDLE.
- At reset ram_req=0 matches a controller ack that also resets to 0. Reset must be asserted together with the controller reset. Reset in mid-transaction discards the FIFO and any pending read.
- Write posting latency: an accepted write reaches ram_* and toggles ram_req no earlier than 1 cycle after the push (FIFO empty, state IDLE).
- Back-to-back drain: after ram_ack matches, the next ram_req toggle occurs 2 cycles later (pop cycle, then issue from IDLE).
- Read latency = drain time of the queued writes + 1 issue cycle + controller latency + 1 cycle (cpu_rdy registered).
- cpu_busy is combinational from registered state. It rises in the cycle after a read is accepted, or the cycle after the FIFO fills.

## Configuration
- SDRAM_WRBUF_RAW_FWD_EN is read-after-write forwarding.
- Defined:
  - When a read is accepted, the FIFO is searched newest-to-oldest for the first matching addr.
  - If that newest match has wrl=wrh=1: cpu_dout<=entry din and cpu_rdy pulses on the next cycle. No SDRAM read is issued and rd_pend is not set.
  - If that newest match is a partial-byte write, or there is no match: normal ordered read.
- Undefined: every read goes to SDRAM after the drain, and no comparators are built.

## Test plan
- Reset, then 8 writes on consecutive cycles (DEPTH_LOG2=3), addr 0x100..0x107, data 0xA000+i → all accepted with cpu_busy=0. A 9th write in the next cycle sees cpu_busy=1. The controller receives exactly 8 toggles in order.
- Write 0x1234 to 0x200 with wrl only, then a read of 0x200 → the read toggle occurs only after the write ack. cpu_rdy pulses once with cpu_dout = model value (low byte 0x34).
- Controller model delays ack 10 cycles while a write arrives in the same cycle as a pop → occupancy is unchanged and no entry is lost or duplicated.
- Assert reset during WR_WAIT with 3 entries queued → all outputs return to reset values next edge. No further ram_req toggles occur without new requests.
- With SDRAM_WRBUF_RAW_FWD_EN: full write of 0xBEEF to 0x300 held in the FIFO (ack stalled), then a read of 0x300 → cpu_rdy with 0xBEEF one cycle after accept and no read toggle. Without the macro → the read is issued after the write retires.
- Random mix of 2000 requests against a byte-accurate SDRAM model and random ack latency 5–20 cycles → every read matches the model and no toggle protocol violation occurs.
